// File: rtl/mem_access_unit.sv
// Memory-stage access engine: runs one req/ack data-memory transaction per load/store and
// stalls the pipeline until it completes, is rejected for alignment, or times out.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_write,
    input  logic        wb_load,
    input  logic [1:0]  mem_store_type,
    input  logic [2:0]  mem_load_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        mem_done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             start, aligned, need_half, need_word, timeout;
    logic             mis_q, berr_q;
    logic [1:0]       off_p0;
    logic [2:0]       ltype_p0;

    function automatic logic [31:0] extend_load(input logic [2:0] ltype, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[8*off +: 8];
        h = rdata[16*off[1] +: 16];
        case (ltype)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b011:  return {24'd0, b};
            3'b100:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
        case (st)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] sd);
        case (st)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    assign start     = in_valid & (wb_load | (mem_write & (mem_store_type != 2'b11)));
    assign need_half = wb_load ? (mem_load_type == 3'b001 || mem_load_type == 3'b100)
                               : (mem_store_type == 2'b01);
    assign need_word = wb_load ? !(mem_load_type == 3'b000 || mem_load_type == 3'b011 ||
                                   mem_load_type == 3'b001 || mem_load_type == 3'b100)
                               : (mem_store_type == 2'b10);
    assign aligned   = !(need_half && addr[0]) && !(need_word && (addr[1:0] != 2'b00));
    assign timeout   = (state == BUSY) && (tmo_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = aligned ? BUSY : DONE;
            BUSY:    if (dmem_ack || timeout) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset drops stall at once even if the stalled instruction is still presented.
    always_comb begin
        stall      = 1'b0;
        dmem_req   = 1'b0;
        mem_done   = 1'b0;
        misaligned = 1'b0;
        bus_error  = 1'b0;
        case (state)
            IDLE: stall = start & ~rst;
            BUSY: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
            end
            DONE: begin
                mem_done   = 1'b1;
                misaligned = mis_q;
                bus_error  = berr_q;
            end
            default: ;
        endcase
    end

    // Request capture stage: fields stay frozen for the whole BUSY period.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && aligned) begin
            off_p0   <= addr[1:0];
            ltype_p0 <= mem_load_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (aligned) begin
                        dmem_we    <= ~wb_load;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= wb_load ? 4'b1111 : store_be(mem_store_type, addr[1:0]);
                        dmem_wdata <= wb_load ? 32'd0 : store_wdata(mem_store_type, store_data);
                    end else begin
                        mis_q     <= 1'b1;
                        load_data <= 32'd0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        load_data <= dmem_we ? 32'd0 : extend_load(ltype_p0, off_p0, dmem_rdata);
                        tmo_cnt   <= '0;
                    end else if (timeout) begin
                        berr_q    <= 1'b1;
                        load_data <= 32'd0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    mis_q   <= 1'b0;
                    berr_q  <= 1'b0;
                    tmo_cnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of accesses with a responding memory model
// and a result scoreboard, plus hand sequences for reset, no-op stores and reset mid-access.
module tb_mem_access_unit;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, mem_write = 1'b0, wb_load = 1'b0;
    logic [1:0]  mem_store_type = 2'b00;
    logic [2:0]  mem_load_type = 3'b000;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        stall, mem_done, misaligned, bus_error;
    logic [31:0] load_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ld;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_at;   // req cycle on which memory acks; 0 = never
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld_exp;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        berr;
    } res_t;

    res_t sb[$];
    vec_t vt[14];

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_write(mem_write), .wb_load(wb_load),
        .mem_store_type(mem_store_type), .mem_load_type(mem_load_type), .addr(addr),
        .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .mem_done(mem_done), .load_data(load_data), .misaligned(misaligned),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        res_t r;
        int   reqc, stc, exp_req;
        logic done_seen;
        r.ld   = v.ld_exp;
        r.mis  = v.mis;
        r.berr = (v.ack_at == 0) && !v.mis;
        sb.push_back(r);
        exp_req = v.mis ? 0 : ((v.ack_at == 0) ? TMO : v.ack_at);

        @(negedge clk);
        in_valid       = 1'b1;
        wb_load        = v.ld;
        mem_write      = ~v.ld;
        mem_store_type = v.ld ? 2'b00 : v.st;
        mem_load_type  = v.lt;
        addr           = v.addr;
        store_data     = v.sd;
        #1;
        chk1($sformatf("v%0d stall_at_start", idx), stall, 1'b1);
        reqc = 0;
        stc = 1;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = 32'd0;
            if (mem_done) begin
                done_seen = 1'b1;
                in_valid  = 1'b0;
                chk32($sformatf("v%0d sb_nonempty", idx), 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) r = sb.pop_front();
                chk32($sformatf("v%0d load_data", idx), load_data, r.ld);
                chk1($sformatf("v%0d misaligned", idx), misaligned, r.mis);
                chk1($sformatf("v%0d bus_error", idx), bus_error, r.berr);
                chk1($sformatf("v%0d stall_in_done", idx), stall, 1'b0);
                chk1($sformatf("v%0d req_in_done", idx), dmem_req, 1'b0);
                chk32($sformatf("v%0d req_cycles", idx), reqc, exp_req);
                chk32($sformatf("v%0d stall_cycles", idx), stc, exp_req + 1);
            end else begin
                if (stall) stc++;
                chk1($sformatf("v%0d req_held", idx), dmem_req, 1'b1);
                if (dmem_req) begin
                    reqc++;
                    chk1($sformatf("v%0d we", idx), dmem_we, ~v.ld);
                    chk32($sformatf("v%0d addr", idx), dmem_addr, v.addr & 32'hFFFF_FFFC);
                    chk32($sformatf("v%0d be", idx), {28'd0, dmem_be}, {28'd0, v.be});
                    if (!v.ld) chk32($sformatf("v%0d wdata", idx), dmem_wdata, v.wd);
                    if (reqc == v.ack_at) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = v.rdata;
                    end
                end
            end
        end
        if (!done_seen) begin
            chk1($sformatf("v%0d mem_done_seen", idx), 1'b0, 1'b1);
            in_valid = 1'b0;
            dmem_ack = 1'b0;
        end
        @(posedge clk);
        #1;
        chk1($sformatf("v%0d done_one_cycle", idx), mem_done, 1'b0);
        chk1($sformatf("v%0d idle_no_stall", idx), stall, 1'b0);
    endtask

    initial begin
        //          ld  st     lt      addr          sd            rdata         ack be       wd            ld_exp        mis
        vt[0]  = '{1'b0, 2'b00, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0,         1, 4'b1000, 32'hDDDD_DDDD, 32'h0,         1'b0};
        vt[1]  = '{1'b1, 2'b00, 3'b000, 32'h0000_2001, 32'h0,         32'h0000_8000, 1, 4'b1111, 32'h0,         32'hFFFF_FF80, 1'b0};
        vt[2]  = '{1'b1, 2'b00, 3'b011, 32'h0000_2001, 32'h0,         32'h0000_8000, 1, 4'b1111, 32'h0,         32'h0000_0080, 1'b0};
        vt[3]  = '{1'b1, 2'b00, 3'b100, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 1, 4'b1111, 32'h0,         32'h0000_BEEF, 1'b0};
        vt[4]  = '{1'b1, 2'b00, 3'b010, 32'h0000_2004, 32'h0,         32'h1234_5678, 6, 4'b1111, 32'h0,         32'h1234_5678, 1'b0};
        vt[5]  = '{1'b1, 2'b00, 3'b001, 32'h0000_3001, 32'h0,         32'h0,         1, 4'b1111, 32'h0,         32'h0,         1'b1};
        vt[6]  = '{1'b1, 2'b00, 3'b010, 32'h0000_4000, 32'h0,         32'hFFFF_FFFF, 0, 4'b1111, 32'h0,         32'h0,         1'b0};
        vt[7]  = '{1'b1, 2'b00, 3'b010, 32'h0000_4008, 32'h0,         32'hCAFE_BABE, TMO, 4'b1111, 32'h0,       32'hCAFE_BABE, 1'b0};
        vt[8]  = '{1'b0, 2'b01, 3'b000, 32'h0000_1002, 32'h1122_3344, 32'h0,         1, 4'b1100, 32'h3344_3344, 32'h0,         1'b0};
        vt[9]  = '{1'b0, 2'b10, 3'b000, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0,         2, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vt[10] = '{1'b1, 2'b00, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_0000, 1, 4'b1111, 32'h0,         32'hFFFF_8001, 1'b0};
        vt[11] = '{1'b1, 2'b00, 3'b111, 32'h0000_2000, 32'h0,         32'hA5A5_A5A5, 3, 4'b1111, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vt[12] = '{1'b0, 2'b10, 3'b000, 32'h0000_1002, 32'h5555_AAAA, 32'h0,         1, 4'b1111, 32'h0,         32'h0,         1'b1};
        vt[13] = '{1'b1, 2'b00, 3'b000, 32'h0000_2003, 32'h0,         32'h7F00_0000, 1, 4'b1111, 32'h0,         32'h0000_007F, 1'b0};

        repeat (2) @(negedge clk);
        chk1("rst dmem_req", dmem_req, 1'b0);
        chk1("rst dmem_we", dmem_we, 1'b0);
        chk32("rst dmem_addr", dmem_addr, 32'd0);
        chk32("rst dmem_be", {28'd0, dmem_be}, 32'd0);
        chk32("rst dmem_wdata", dmem_wdata, 32'd0);
        chk1("rst stall", stall, 1'b0);
        chk1("rst mem_done", mem_done, 1'b0);
        chk32("rst load_data", load_data, 32'd0);
        chk1("rst misaligned", misaligned, 1'b0);
        chk1("rst bus_error", bus_error, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

        // Store with type 11 is a no-op.
        @(negedge clk);
        in_valid = 1'b1; wb_load = 1'b0; mem_write = 1'b1; mem_store_type = 2'b11;
        addr = 32'h0000_1000; store_data = 32'h1234_5678;
        #1;
        chk1("noop stall_comb", stall, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk1("noop req", dmem_req, 1'b0);
            chk1("noop stall", stall, 1'b0);
            chk1("noop mem_done", mem_done, 1'b0);
        end
        in_valid = 1'b0; mem_write = 1'b0;

        // Reset while a load is outstanding.
        @(negedge clk);
        in_valid = 1'b1; wb_load = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_5000;
        repeat (3) @(posedge clk);
        #1;
        chk1("midrst req_before", dmem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("midrst req", dmem_req, 1'b0);
        chk1("midrst stall", stall, 1'b0);
        chk1("midrst mem_done", mem_done, 1'b0);
        chk32("midrst be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; wb_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("postrst req", dmem_req, 1'b0);
        chk1("postrst stall", stall, 1'b0);
        chk1("postrst mem_done", mem_done, 1'b0);

        chk32("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
